// File: rtl/blk_norm_if.sv
// Stream interface for blk_norm: sample input port plus normalized output port
// with its shared block exponent.
interface blk_norm_if #(
  parameter int A_WIDTH     = 32,
  parameter int F_WIDTH     = 16,
  parameter int SHIFT_WIDTH = $clog2(A_WIDTH)
);
  logic [A_WIDTH-1:0]     a;
  logic                   a_valid;
  logic                   a_ready;
  logic [F_WIDTH-1:0]     f;
  logic                   f_valid;
  logic                   f_ready;
  logic                   f_last;
  logic [SHIFT_WIDTH-1:0] f_shift;

  modport master (
    output a, a_valid, f_ready,
    input  a_ready, f, f_valid, f_last, f_shift
  );

  modport slave (
    input  a, a_valid, f_ready,
    output a_ready, f, f_valid, f_last, f_shift
  );
endinterface

// File: rtl/blk_norm.sv
// Block-floating-point normalizer: buffers BLOCK_LEN samples, finds the common
// headroom, then replays the block shifted left by it and truncated to F_WIDTH.
module blk_norm #(
  parameter int A_WIDTH     = 32,
  parameter int F_WIDTH     = 16,
  parameter int BLOCK_LEN   = 8,
  parameter int SHIFT_WIDTH = $clog2(A_WIDTH)
) (
  input  logic      clk,
  input  logic      reset_l,
  blk_norm_if.slave bus
);

  localparam int PTR_WIDTH = $clog2(BLOCK_LEN);
  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(BLOCK_LEN - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [A_WIDTH-1:0]     mem_q [BLOCK_LEN];
  logic [A_WIDTH-1:0]     mem_d [BLOCK_LEN];
  logic [PTR_WIDTH-1:0]   wptr_q, wptr_d;
  logic [PTR_WIDTH-1:0]   rptr_q, rptr_d;
  logic [SHIFT_WIDTH-1:0] runmin_q, runmin_d;
  logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic [F_WIDTH-1:0]     f_q, f_d;
  logic                   f_valid_q, f_valid_d;
  logic                   f_last_q, f_last_d;
  logic                   a_ready_q, a_ready_d;

  logic [SHIFT_WIDTH-1:0] h_s;
  logic [SHIFT_WIDTH-1:0] min_s;
  logic [PTR_WIDTH-1:0]   rptr_inc_s;

  // Redundant sign bits: leading bits equal to the MSB, not counting the MSB itself.
  function automatic logic [SHIFT_WIDTH-1:0] headroom(input logic [A_WIDTH-1:0] x);
    logic [SHIFT_WIDTH-1:0] cnt;
    logic                   run;
    cnt = {SHIFT_WIDTH{1'b0}};
    run = 1'b1;
    for (int i = A_WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[A_WIDTH-1])) begin
        cnt = cnt + SHIFT_WIDTH'(1);
      end else begin
        run = 1'b0;
      end
    end
    return cnt;
  endfunction

  function automatic logic [F_WIDTH-1:0] normalize(input logic [A_WIDTH-1:0] x,
                                                   input logic [SHIFT_WIDTH-1:0] s);
    logic [A_WIDTH-1:0] shifted;
    shifted = x << s;
    return shifted[A_WIDTH-1 -: F_WIDTH];
  endfunction

  assign bus.a_ready = a_ready_q;
  assign bus.f       = f_q;
  assign bus.f_valid = f_valid_q;
  assign bus.f_last  = f_last_q;
  assign bus.f_shift = shift_q;

  // Next-state decode for the fill/drain sequencer and its registered outputs.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    runmin_d  = runmin_q;
    shift_d   = shift_q;
    f_d       = f_q;
    f_valid_d = f_valid_q;
    f_last_d  = f_last_q;

    h_s        = headroom(bus.a);
    rptr_inc_s = rptr_q + PTR_WIDTH'(1);
    // The first sample of a block restarts the running minimum.
    if ((wptr_q == {PTR_WIDTH{1'b0}}) || (h_s < runmin_q)) begin
      min_s = h_s;
    end else begin
      min_s = runmin_q;
    end

    case (state_q)
      FILL: begin
        if (bus.a_valid && a_ready_q) begin
          mem_d[wptr_q] = bus.a;
          runmin_d      = min_s;
          if (wptr_q == LAST_IDX) begin
            wptr_d    = {PTR_WIDTH{1'b0}};
            shift_d   = min_s;
            state_d   = DRAIN;
            f_valid_d = 1'b1;
            f_last_d  = 1'b0;
            f_d       = normalize(mem_q[0], min_s);
          end else begin
            wptr_d = wptr_q + PTR_WIDTH'(1);
          end
        end else begin
          wptr_d = wptr_q;
        end
      end
      DRAIN: begin
        if (f_valid_q && bus.f_ready) begin
          if (rptr_q == LAST_IDX) begin
            rptr_d    = {PTR_WIDTH{1'b0}};
            state_d   = FILL;
            f_valid_d = 1'b0;
            f_last_d  = 1'b0;
          end else begin
            rptr_d   = rptr_inc_s;
            f_d      = normalize(mem_q[rptr_inc_s], shift_q);
            f_last_d = (rptr_inc_s == LAST_IDX);
          end
        end else begin
          rptr_d = rptr_q;
        end
      end
      default: begin
        state_d   = FILL;
        f_valid_d = 1'b0;
        f_last_d  = 1'b0;
      end
    endcase

    a_ready_d = (state_d == FILL);
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state_q   <= FILL;
      wptr_q    <= {PTR_WIDTH{1'b0}};
      rptr_q    <= {PTR_WIDTH{1'b0}};
      runmin_q  <= {SHIFT_WIDTH{1'b0}};
      shift_q   <= {SHIFT_WIDTH{1'b0}};
      f_q       <= {F_WIDTH{1'b0}};
      f_valid_q <= 1'b0;
      f_last_q  <= 1'b0;
      a_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      runmin_q  <= runmin_d;
      shift_q   <= shift_d;
      f_q       <= f_d;
      f_valid_q <= f_valid_d;
      f_last_q  <= f_last_d;
      a_ready_q <= a_ready_d;
    end
  end

  // Sample buffer; never read before a full block is written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_blk_norm.sv
// Directed-table and random scoreboard bench for blk_norm (A=16, F=8, BLOCK_LEN=4).
module tb_blk_norm;

  localparam int AW   = 16;
  localparam int FW   = 8;
  localparam int BL   = 4;
  localparam int SW   = 4;
  localparam int NBLK = 1000;

  logic clk;
  logic reset_l;
  int   checks;
  int   errors;

  blk_norm_if #(.A_WIDTH(AW), .F_WIDTH(FW), .SHIFT_WIDTH(SW)) bus ();

  blk_norm #(.A_WIDTH(AW), .F_WIDTH(FW), .BLOCK_LEN(BL), .SHIFT_WIDTH(SW)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] a;
    logic [3:0]       s;
    logic [3:0][7:0]  f;
  } vec_t;

  vec_t vecs [6];
  logic [15:0] sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_vec(input int k,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3,
                         input logic [3:0] s,
                         input logic [7:0] f0, input logic [7:0] f1,
                         input logic [7:0] f2, input logic [7:0] f3);
    vecs[k].a[0] = a0; vecs[k].a[1] = a1; vecs[k].a[2] = a2; vecs[k].a[3] = a3;
    vecs[k].s    = s;
    vecs[k].f[0] = f0; vecs[k].f[1] = f1; vecs[k].f[2] = f2; vecs[k].f[3] = f3;
  endtask

  // Presents the first n samples of vector k; returns just after the last accept edge.
  task automatic feed(input int k, input int n);
    int waits;
    for (int i = 0; i < n; i++) begin
      bus.a       = vecs[k].a[i];
      bus.a_valid = 1'b1;
      waits = 0;
      while (!bus.a_ready && waits < 40) begin
        @(posedge clk); #1;
        waits++;
      end
      check($sformatf("v%0d_a_ready_s%0d", k, i), 32'(bus.a_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus.a_valid = 1'b0;
  endtask

  task automatic drain(input int k, input int start);
    bus.f_ready = 1'b1;
    for (int j = start; j < 4; j++) begin
      check($sformatf("v%0d_f_valid%0d", k, j), 32'(bus.f_valid), 32'd1);
      check($sformatf("v%0d_f%0d", k, j), 32'(bus.f), 32'(vecs[k].f[j]));
      check($sformatf("v%0d_f_last%0d", k, j), 32'(bus.f_last), 32'(j == 3));
      check($sformatf("v%0d_f_shift%0d", k, j), 32'(bus.f_shift), 32'(vecs[k].s));
      check($sformatf("v%0d_a_ready_drain%0d", k, j), 32'(bus.a_ready), 32'd0);
      @(posedge clk); #1;
    end
    check($sformatf("v%0d_f_valid_done", k), 32'(bus.f_valid), 32'd0);
    check($sformatf("v%0d_a_ready_done", k), 32'(bus.a_ready), 32'd1);
  endtask

  // Reference headroom: largest shift that survives a left/arith-right round trip.
  function automatic logic [3:0] ref_h(input logic [15:0] x);
    logic [15:0] t1;
    logic [15:0] t2;
    logic [3:0]  best;
    best = 4'd0;
    for (int s = 1; s < 16; s++) begin
      t1 = x << s;
      t2 = $signed(t1) >>> s;
      if (t2 == x) best = 4'(s);
    end
    return best;
  endfunction

  function automatic logic [7:0] ref_f(input logic [15:0] x, input logic [3:0] s);
    logic [15:0] t;
    t = x << s;
    return t[15:8];
  endfunction

  function automatic logic [15:0] gen_sample();
    logic [15:0] v;
    int          sel;
    sel = int'($urandom_range(0, 19));
    v   = 16'($urandom);
    if (sel == 0) v = 16'h0000;
    else if (sel == 1) v = 16'h8000;
    else v = 16'($signed(v) >>> $urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    bus.a       = 16'h0000;
    bus.a_valid = 1'b0;
    bus.f_ready = 1'b0;
    reset_l     = 1'b0;

    set_vec(0, 16'h0010, 16'hFFF0, 16'h0001, 16'h0000, 4'd10, 8'h40, 8'hC0, 8'h04, 8'h00);
    set_vec(1, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFF, 4'd0,  8'h80, 8'h7F, 8'h00, 8'hFF);
    set_vec(2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd15, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(3, 16'h0123, 16'hFF00, 16'h00FF, 16'h0040, 4'd6,  8'h48, 8'hC0, 8'h3F, 8'h10);
    set_vec(4, 16'hFFFF, 16'hFFFE, 16'hFFFC, 16'h0003, 4'd13, 8'hE0, 8'hC0, 8'h80, 8'h60);
    set_vec(5, 16'h4000, 16'h1234, 16'hEDCB, 16'h0000, 4'd0,  8'h40, 8'h12, 8'hED, 8'h00);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_ready", 32'(bus.a_ready), 32'd0);
    check("rst_f_valid", 32'(bus.f_valid), 32'd0);
    check("rst_f_last", 32'(bus.f_last), 32'd0);
    check("rst_f", 32'(bus.f), 32'd0);
    check("rst_f_shift", 32'(bus.f_shift), 32'd0);
    reset_l = 1'b1;
    @(posedge clk); #1;
    check("rel_a_ready", 32'(bus.a_ready), 32'd1);
    check("rel_f_valid", 32'(bus.f_valid), 32'd0);

    // Table: each block fed back-to-back and drained at full rate
    for (int k = 0; k < 6; k++) begin
      feed(k, 4);
      drain(k, 0);
    end

    // Stall on sample 1 with a_valid pulses during drain
    feed(0, 4);
    check("stall_f0", 32'(bus.f), 32'h40);
    bus.f_ready = 1'b1;
    @(posedge clk); #1;
    bus.f_ready = 1'b0;
    bus.a       = 16'h7777;
    for (int c = 0; c < 3; c++) begin
      bus.a_valid = (c != 1);
      check($sformatf("stall_valid%0d", c), 32'(bus.f_valid), 32'd1);
      check($sformatf("stall_f%0d", c), 32'(bus.f), 32'hC0);
      check($sformatf("stall_last%0d", c), 32'(bus.f_last), 32'd0);
      check($sformatf("stall_shift%0d", c), 32'(bus.f_shift), 32'd10);
      check($sformatf("stall_a_ready%0d", c), 32'(bus.a_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.a_valid = 1'b0;
    drain(0, 1);
    feed(3, 4);
    drain(3, 0);

    // Reset after two accepted samples
    feed(2, 2);
    reset_l = 1'b0;
    @(posedge clk); #1;
    check("rfill_f_valid", 32'(bus.f_valid), 32'd0);
    check("rfill_a_ready", 32'(bus.a_ready), 32'd0);
    reset_l = 1'b1;
    @(posedge clk); #1;
    check("rfill_a_ready_rel", 32'(bus.a_ready), 32'd1);
    feed(1, 4);
    drain(1, 0);

    // Reset after two drained outputs
    feed(4, 4);
    bus.f_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.f_ready = 1'b0;
    check("rdrain_pre_valid", 32'(bus.f_valid), 32'd1);
    reset_l = 1'b0;
    @(posedge clk); #1;
    check("rdrain_f_valid", 32'(bus.f_valid), 32'd0);
    check("rdrain_a_ready", 32'(bus.a_ready), 32'd0);
    check("rdrain_f_last", 32'(bus.f_last), 32'd0);
    reset_l = 1'b1;
    @(posedge clk); #1;
    check("rdrain_a_ready_rel", 32'(bus.a_ready), 32'd1);
    check("rdrain_f_valid_rel", 32'(bus.f_valid), 32'd0);
    feed(5, 4);
    drain(5, 0);

    // Random traffic against the reference model
    fork
      begin : driver
        int          sent;
        int          cyc;
        logic [15:0] cur;
        logic        acc;
        sent = 0;
        cyc  = 0;
        cur  = gen_sample();
        while (sent < NBLK * 4 && cyc < 80000) begin
          bus.a       = cur;
          bus.a_valid = ($urandom_range(0, 3) != 0);
          acc = bus.a_valid && bus.a_ready;
          if (acc) begin
            sb_q.push_back(cur);
            sent++;
          end
          @(posedge clk); #1;
          cyc++;
          if (acc) cur = gen_sample();
        end
        bus.a_valid = 1'b0;
      end
      begin : monitor
        int          got;
        int          cyc;
        int          idx;
        logic        hs;
        logic [3:0]  s_exp;
        logic [15:0] blk [4];
        got   = 0;
        cyc   = 0;
        idx   = 0;
        s_exp = 4'd0;
        for (int i = 0; i < 4; i++) blk[i] = 16'h0000;
        while (got < NBLK * 4 && cyc < 80000) begin
          bus.f_ready = ($urandom_range(0, 2) != 0);
          hs = bus.f_valid && bus.f_ready;
          if (hs) begin
            if (idx == 0) begin
              check("rand_sb_depth", 32'(sb_q.size() >= 4), 32'd1);
              s_exp = 4'd15;
              for (int i = 0; i < 4; i++) begin
                blk[i] = (sb_q.size() > 0) ? sb_q.pop_front() : 16'h0000;
                if (ref_h(blk[i]) < s_exp) s_exp = ref_h(blk[i]);
              end
            end
            check($sformatf("rand_f_b%0d_s%0d", got / 4, idx), 32'(bus.f), 32'(ref_f(blk[idx], s_exp)));
            check($sformatf("rand_last_b%0d_s%0d", got / 4, idx), 32'(bus.f_last), 32'(idx == 3));
            check($sformatf("rand_shift_b%0d_s%0d", got / 4, idx), 32'(bus.f_shift), 32'(s_exp));
            idx = (idx + 1) % 4;
            got++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        bus.f_ready = 1'b0;
        check("rand_output_count", 32'(got), 32'(NBLK * 4));
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
